// File: rtl/alu_rx_tx_interface_pkg.sv
// Shared definitions for the UART <-> ALU sequencing stage: FSM encoding and ALU opcodes.
// Benches and the ALU use these opcodes too, so there is a single source of truth.
package alu_rx_tx_interface_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_rx_tx_interface_frame_timer.sv
// Inter-byte idle counter: expired is combinational, high in the last allowed idle cycle.
// No backpressure; TIMEOUT=0 keeps the count at 0 and never expires.
module frame_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clear || expired || (TIMEOUT == 0)) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_rx_tx_interface.sv
// Collects A, B, opcode from the UART receiver, presents them to the ALU, then sends RESULT
// with a one-cycle TX_START one cycle after the opcode lands; bytes arriving while BUSY are dropped.
module alu_rx_tx_interface
    import alu_rx_tx_interface_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int TIMEOUT  = 50000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RX_DONE,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                TX_DONE,
    input  logic [SIZEDATA-1:0] RESULT,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic                TX_START,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                BUSY
);

    state_t state;
    state_t state_nxt;

    logic ld_a;
    logic ld_b;
    logic ld_op;
    logic ld_tx;
    logic tmr_clear;
    logic tmr_en;
    logic tmr_exp;

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_exp)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= WAIT_A;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A:  if (RX_DONE) state_nxt = WAIT_B;
            WAIT_B:  begin
                if (RX_DONE)      state_nxt = WAIT_OP;
                else if (tmr_exp) state_nxt = WAIT_A;
            end
            WAIT_OP: begin
                if (RX_DONE)      state_nxt = CALC;
                else if (tmr_exp) state_nxt = WAIT_A;
            end
            CALC:    state_nxt = WAIT_TX;
            WAIT_TX: if (TX_DONE) state_nxt = WAIT_A;
            default: state_nxt = WAIT_A;
        endcase
    end

    always_comb begin
        ld_a      = (state == WAIT_A)  && RX_DONE;
        ld_b      = (state == WAIT_B)  && RX_DONE;
        ld_op     = (state == WAIT_OP) && RX_DONE;
        ld_tx     = (state == CALC);
        tmr_en    = ((state == WAIT_B) || (state == WAIT_OP)) && !RX_DONE;
        tmr_clear = !tmr_en;
        BUSY      = (state == CALC) || (state == WAIT_TX);
    end

    // Operand and result registers hold across frames; only reset clears them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DATOA    <= '0;
            DATOB    <= '0;
            OPCODE   <= '0;
            TX_DATA  <= '0;
            TX_START <= 1'b0;
        end else begin
            if (ld_a)  DATOA   <= RX_DATA;
            if (ld_b)  DATOB   <= RX_DATA;
            if (ld_op) OPCODE  <= RX_DATA[SIZEOP-1:0];
            if (ld_tx) TX_DATA <= RESULT;
            TX_START <= ld_tx;
        end
    end

endmodule

// File: tb/tb_alu_rx_tx_interface.sv
// Directed bench for alu_rx_tx_interface with a behavioural ALU on RESULT and TIMEOUT=16.
module tb_alu_rx_tx_interface;
    import alu_rx_tx_interface_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX_DONE;
    logic [7:0] RX_DATA;
    logic       TX_DONE;
    logic [7:0] RESULT;
    logic [7:0] DATOA;
    logic [7:0] DATOB;
    logic [5:0] OPCODE;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       BUSY;

    int n_cmp = 0;
    int n_err = 0;

    alu_rx_tx_interface #(
        .SIZEDATA (8),
        .SIZEOP   (6),
        .TIMEOUT  (16)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RX_DONE  (RX_DONE),
        .RX_DATA  (RX_DATA),
        .TX_DONE  (TX_DONE),
        .RESULT   (RESULT),
        .DATOA    (DATOA),
        .DATOB    (DATOB),
        .OPCODE   (OPCODE),
        .TX_START (TX_START),
        .TX_DATA  (TX_DATA),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        case (OPCODE)
            OP_ADD:  RESULT = DATOA + DATOB;
            OP_SUB:  RESULT = DATOA - DATOB;
            OP_AND:  RESULT = DATOA & DATOB;
            OP_OR:   RESULT = DATOA | DATOB;
            OP_XOR:  RESULT = DATOA ^ DATOB;
            OP_NOR:  RESULT = ~(DATOA | DATOB);
            OP_SRA:  RESULT = 8'($signed(DATOA) >>> DATOB);
            OP_SRL:  RESULT = DATOA >> DATOB;
            default: RESULT = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with RX_DONE low.
    task automatic send(input logic [7:0] b);
        RX_DATA = b;
        RX_DONE = 1'b1;
        @(negedge CLK);
        RX_DONE = 1'b0;
    endtask

    task automatic pulse_tx_done();
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
    endtask

    // Starts right after the opcode byte was captured (state CALC).
    task automatic finish_tx(input string tag, input logic [7:0] exp_tx);
        chk({tag, "_busy_calc"}, 32'(BUSY), 32'd1);
        chk({tag, "_start_calc"}, 32'(TX_START), 32'd0);
        @(negedge CLK);
        chk({tag, "_start"}, 32'(TX_START), 32'd1);
        chk({tag, "_txdata"}, 32'(TX_DATA), 32'(exp_tx));
        @(negedge CLK);
        chk({tag, "_start_once"}, 32'(TX_START), 32'd0);
        chk({tag, "_busy_wtx"}, 32'(BUSY), 32'd1);
        pulse_tx_done();
        chk({tag, "_busy_done"}, 32'(BUSY), 32'd0);
        chk({tag, "_state_done"}, 32'(dut.state), 32'(WAIT_A));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [5:0] exp_op,
                             input logic [7:0] exp_tx);
        send(a);
        chk({tag, "_a"}, 32'(DATOA), 32'(a));
        send(b);
        chk({tag, "_b"}, 32'(DATOB), 32'(b));
        send(op);
        chk({tag, "_op"}, 32'(OPCODE), 32'(exp_op));
        finish_tx(tag, exp_tx);
    endtask

    initial begin
        RESET   = 1'b1;
        RX_DONE = 1'b0;
        RX_DATA = 8'h00;
        TX_DONE = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_datoa", 32'(DATOA), 32'd0);
        chk("rst_datob", 32'(DATOB), 32'd0);
        chk("rst_opcode", 32'(OPCODE), 32'd0);
        chk("rst_txdata", 32'(TX_DATA), 32'd0);
        chk("rst_txstart", 32'(TX_START), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(WAIT_A));
        RESET = 1'b0;
        @(negedge CLK);

        run_frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        run_frame("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
        run_frame("sra", 8'h80, 8'h02, 8'h03, 6'h03, 8'hE0);
        run_frame("mask", 8'h10, 8'h07, 8'hE0, 6'h20, 8'h17);

        // Timeout: 16 idle cycles in WAIT_B return to WAIT_A.
        send(8'h11);
        chk("to_a", 32'(DATOA), 32'h11);
        repeat (15) @(negedge CLK);
        chk("to_before", 32'(dut.state), 32'(WAIT_B));
        @(negedge CLK);
        chk("to_expired", 32'(dut.state), 32'(WAIT_A));
        chk("to_keep_a", 32'(DATOA), 32'h11);
        run_frame("to_next", 8'h01, 8'h01, 8'h20, 6'h20, 8'h02);

        // Byte landing in the expiry cycle is accepted as B.
        send(8'h11);
        repeat (15) @(negedge CLK);
        send(8'h22);
        chk("exp_b", 32'(DATOB), 32'h22);
        chk("exp_state", 32'(dut.state), 32'(WAIT_OP));
        send(8'h20);
        finish_tx("exp", 8'h33);

        // Byte during WAIT_TX is dropped; stray TX_DONE in WAIT_B is ignored.
        send(8'h09);
        send(8'h04);
        send(8'h20);
        @(negedge CLK);
        chk("drop_tx", 32'(TX_DATA), 32'h0D);
        send(8'h77);
        chk("drop_a", 32'(DATOA), 32'h09);
        chk("drop_b", 32'(DATOB), 32'h04);
        chk("drop_state", 32'(dut.state), 32'(WAIT_TX));
        pulse_tx_done();
        send(8'h0A);
        chk("stray_a", 32'(DATOA), 32'h0A);
        pulse_tx_done();
        chk("stray_state", 32'(dut.state), 32'(WAIT_B));
        send(8'h01);
        chk("stray_b", 32'(DATOB), 32'h01);
        send(8'h20);
        finish_tx("stray", 8'h0B);

        // Asynchronous reset mid-frame clears everything immediately.
        send(8'h05);
        send(8'h03);
        chk("mid_a", 32'(DATOA), 32'h05);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_a", 32'(DATOA), 32'd0);
        chk("mid_rst_b", 32'(DATOB), 32'd0);
        chk("mid_rst_op", 32'(OPCODE), 32'd0);
        chk("mid_rst_tx", 32'(TX_DATA), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(WAIT_A));
        @(negedge CLK);
        chk("mid_rst_start", 32'(TX_START), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        run_frame("or", 8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
